// File: rtl/regfile_init_bypass.sv
// -----------------------------------------------------------------------------
// regfile_init_bypass
//
// Single-write, dual-read register file for the decode stage. It feeds the ALU
// operand muxes.
//
// After reset, or after a clr request, a walker loads every register in
// sequence, one per clock. The stack-pointer register gets SP_INIT and every
// other register gets zero. Reads return zero and writes are refused until the
// walk finishes and ready rises. Register 0 is hard-wired to read zero.
//
// Parameters
//   DATA_WIDTH : register width in bits
//   ADDR_WIDTH : index width; DEPTH = 2**ADDR_WIDTH registers
//   SP_INDEX   : register loaded with SP_INIT during init (1..DEPTH-1)
//   SP_INIT    : init value for SP_INDEX (truncated/zero-extended)
//   BYPASS     : 1 = same-cycle write data forwarded to the read ports
//
// Ports
//   clk      in   clock; all state updates on the rising edge
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous request to re-run initialisation (RUN only)
//   we3      in   write enable
//   a1, a2   in   read addresses
//   a3       in   write address
//   wd3      in   write data
//   rd1, rd2 out  combinational read data
//   ready    out  high in RUN; writes are accepted only while high
//   wr_drop  out  registered one-cycle pulse: a write request was discarded
// -----------------------------------------------------------------------------
module regfile_init_bypass #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 5,
  parameter int          SP_INDEX   = 2,
  parameter logic [31:0] SP_INIT    = 32'h7fff_efe4,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] a1,
  input  logic [ADDR_WIDTH-1:0] a2,
  input  logic [ADDR_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic                  ready,
  output logic                  wr_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Index of the last register, the stack-pointer index, and the stack-pointer
  // init value, each resized to the width of the signal it is compared with or
  // loaded into.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] SP_IDX   = ADDR_WIDTH'(SP_INDEX);
  localparam logic [DATA_WIDTH-1:0] SP_VAL   = DATA_WIDTH'(SP_INIT);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q,    state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    wr_drop_q,  wr_drop_d;

  // Array write port, shared by the init walker and the normal write path.
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // A write request that would actually change the array. Writes to x0 are
  // discarded silently, so they never count as dropped.
  logic wr_req;
  assign wr_req = we3 && (a3 != '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement leaves one unassigned. That prevents
    // latch inference.
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wr_drop_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = a3;
    mem_wdata  = wd3;

    unique case (state_q)
      ST_INIT: begin
        // The walker owns the write port. clr is ignored and any real write
        // request is refused, which shows up as wr_drop.
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = (init_cnt_q == SP_IDX) ? SP_VAL : '0;
        init_cnt_d = init_cnt_q + 1'b1;      // wraps to 0 after LAST_IDX
        wr_drop_d  = wr_req;
        if (init_cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (clr) begin
          // clr wins over a write in the same cycle.
          state_d    = ST_INIT;
          init_cnt_d = '0;
          wr_drop_d  = wr_req;
        end else begin
          mem_we = wr_req;
        end
      end

      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state: asynchronous reset puts the block back at the start of init
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples values from before the edge, whatever order the blocks
    // run in.
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. The init walker gives it defined contents,
  // and reads are forced to zero until then. This lets it map onto plain
  // storage without a reset network.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Priority: not ready -> 0, x0 -> 0, same-cycle bypass -> wd3, else the array.
  // Bypass applies only in RUN, so it sits below the ready gate.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  run,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] value;
    value = '0;
    if (run && (addr != '0)) begin
      if (BYPASS && wr_en && (wr_addr == addr)) begin
        value = wr_data;
      end else begin
        value = stored;
      end
    end
    return value;
  endfunction

  logic run;
  assign run = (state_q == ST_RUN);

  always_comb begin
    rd1 = read_port(run, a1, we3, a3, wd3, mem_q[a1]);
    rd2 = read_port(run, a2, we3, a3, wd3, mem_q[a2]);
  end

  // ready follows the state register. Asynchronous reset clears the state,
  // so ready drops as soon as rst_n falls.
  assign ready   = run;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_init_bypass.sv
// -----------------------------------------------------------------------------
// tb_regfile_init_bypass
//
// Directed bench for regfile_init_bypass. Two instances share every input:
// dut_b has BYPASS=1 and dut_n has BYPASS=0, so the two read behaviours can be
// compared cycle for cycle. Inputs change 1 ns after a rising edge, and
// outputs are sampled 1 ns after that (combinational) or 1 ns after the next
// rising edge (registered).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_init_bypass;

  localparam int          DW    = 32;
  localparam int          AW    = 5;
  localparam int          DEPTH = 32;
  localparam logic [31:0] SP    = 32'h7fff_efe4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          we3;
  logic [AW-1:0] a1, a2, a3;
  logic [DW-1:0] wd3;

  logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic          ready_b, ready_n, drop_b, drop_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_init_bypass #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we3(we3),
    .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1_b), .rd2(rd2_b), .ready(ready_b), .wr_drop(drop_b)
  );

  regfile_init_bypass #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we3(we3),
    .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1_n), .rd2(rd2_n), .ready(ready_n), .wr_drop(drop_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs DEPTH init edges, checking that ready stays low until the last one.
  // mode 1 presents a write to r9 before init edge 10, checks that INIT does
  // not bypass it, and checks the wr_drop pulse. mode 2 raises clr before
  // init edge 5, which INIT must ignore.
  task automatic run_init(input int mode);
    for (int i = 1; i <= DEPTH; i++) begin
      if (mode == 1 && i == 10) begin
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'h55; a1 = 5'd9;
        #1;
        checks++;
        if (rd1_b !== 32'h0) begin
          errors++;
          $display("FAIL init_no_bypass: rd1=%h expected %h", rd1_b, 32'h0);
        end
      end
      if (mode == 2 && i == 5) clr = 1'b1;
      step();
      we3 = 1'b0; clr = 1'b0;
      checks++;
      if (ready_b !== (i == DEPTH) || ready_n !== (i == DEPTH)) begin
        errors++;
        $display("FAIL init_ready edge %0d: ready_b=%b ready_n=%b expected %b",
                 i, ready_b, ready_n, (i == DEPTH));
      end
      if (mode == 1 && (i == 10 || i == 11)) begin
        checks++;
        if (drop_b !== (i == 10) || drop_n !== (i == 10)) begin
          errors++;
          $display("FAIL init_wr_drop edge %0d: drop_b=%b drop_n=%b expected %b",
                   i, drop_b, drop_n, (i == 10));
        end
      end
    end
  endtask

  // Checks the contents of one register on port 1 (BYPASS=1 instance) and
  // port 2 (BYPASS=0 instance). we3 must be low so that no bypass is active.
  task automatic expect_reg(input logic [AW-1:0] idx, input logic [DW-1:0] exp,
                            input string tag);
    a1 = idx; a2 = idx;
    #1;
    checks++;
    if (rd1_b !== exp || rd2_n !== exp) begin
      errors++;
      $display("FAIL %s r%0d: rd1_b=%h rd2_n=%h expected %h", tag, idx, rd1_b, rd2_n, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; we3 = 1'b0; a1 = 5'd2; a2 = 5'd2; a3 = '0; wd3 = '0;
    #2;
    repeat (3) step();
    checks++;
    if (ready_b !== 1'b0 || drop_b !== 1'b0 || rd1_b !== 32'h0 || rd2_b !== 32'h0 ||
        ready_n !== 1'b0 || rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b drop=%b rd1=%h rd2=%h expected 0 0 0 0",
               ready_b, drop_b, rd1_b, rd2_b);
    end
  endtask

  task automatic test_init();
    @(negedge clk);
    rst_n = 1'b1;
    run_init(1);
    expect_reg(5'd2, SP,    "init_sp");
    expect_reg(5'd5, 32'h0, "init_zero");
    expect_reg(5'd9, 32'h0, "init_dropped_write");
    expect_reg(5'd0, 32'h0, "init_x0");
  endtask

  task automatic test_write_bypass();
    a1 = 5'd7; a2 = 5'd7; a3 = 5'd7; wd3 = 32'hdead_beef; we3 = 1'b1;
    #1;
    checks++;
    if (rd1_b !== 32'hdead_beef || rd2_b !== 32'hdead_beef) begin
      errors++;
      $display("FAIL bypass_same_cycle: rd1=%h rd2=%h expected %h", rd1_b, rd2_b, 32'hdead_beef);
    end
    checks++;
    if (rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL no_bypass_old_value: rd1=%h expected %h", rd1_n, 32'h0);
    end
    step();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1_n !== 32'hdead_beef || rd1_b !== 32'hdead_beef || drop_b !== 1'b0) begin
      errors++;
      $display("FAIL write_visible: rd1_n=%h rd1_b=%h drop=%b expected %h %h 0",
               rd1_n, rd1_b, drop_b, 32'hdead_beef, 32'hdead_beef);
    end
  endtask

  task automatic test_x0();
    a1 = 5'd0; a3 = 5'd0; wd3 = 32'h1234_5678; we3 = 1'b1;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL x0_bypass: rd1_b=%h rd1_n=%h expected 0", rd1_b, rd1_n);
    end
    step();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || drop_b !== 1'b0 || drop_n !== 1'b0) begin
      errors++;
      $display("FAIL x0_after: rd1=%h drop=%b expected 0 0", rd1_b, drop_b);
    end
  endtask

  task automatic test_back_to_back();
    // Write r4 then r5 on consecutive edges. While r5 is being written, port 1
    // reads r4 (the stored value) and port 2 reads r5 (bypass only in dut_b).
    a3 = 5'd4; wd3 = 32'h0000_0a04; we3 = 1'b1;
    step();
    a3 = 5'd5; wd3 = 32'h0000_0b05; a1 = 5'd4; a2 = 5'd5;
    #1;
    checks++;
    if (rd1_b !== 32'h0000_0a04 || rd2_b !== 32'h0000_0b05 || rd2_n !== 32'h0) begin
      errors++;
      $display("FAIL b2b_mixed: rd1_b=%h rd2_b=%h rd2_n=%h expected %h %h %h",
               rd1_b, rd2_b, rd2_n, 32'h0000_0a04, 32'h0000_0b05, 32'h0);
    end
    step();
    we3 = 1'b0;
    expect_reg(5'd5, 32'h0000_0b05, "b2b_r5");
    expect_reg(5'd4, 32'h0000_0a04, "b2b_r4");
  endtask

  task automatic test_clr();
    expect_reg(5'd7, 32'hdead_beef, "clr_pre_r7");
    clr = 1'b1; we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_00aa;
    step();
    clr = 1'b0; we3 = 1'b0;
    #1;
    checks++;
    if (ready_b !== 1'b0 || drop_b !== 1'b1 || drop_n !== 1'b1 || rd1_b !== 32'h0) begin
      errors++;
      $display("FAIL clr_edge: ready=%b drop=%b rd1=%h expected 0 1 0", ready_b, drop_b, rd1_b);
    end
    // The clr edge consumed no init step. Run the full walk, with a clr
    // raised mid-walk that INIT must ignore.
    run_init(2);
    expect_reg(5'd7, 32'h0, "clr_r7");
    expect_reg(5'd3, 32'h0, "clr_r3");
    expect_reg(5'd2, SP,    "clr_sp");
  endtask

  task automatic test_reset_midrun();
    a3 = 5'd7; wd3 = 32'hdead_beef; we3 = 1'b1;
    step();
    we3 = 1'b0;
    expect_reg(5'd7, 32'hdead_beef, "midrun_pre");
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready_b !== 1'b0 || rd1_b !== 32'h0 || ready_n !== 1'b0 || rd2_n !== 32'h0) begin
      errors++;
      $display("FAIL midrun_reset_async: ready=%b rd1=%h expected 0 0", ready_b, rd1_b);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    run_init(0);
    expect_reg(5'd7, 32'h0, "midrun_r7");
    expect_reg(5'd2, SP,    "midrun_sp");
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_bypass();
    test_x0();
    test_back_to_back();
    test_clr();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
